amm_traffic_driver: RTL
=======================

# amm_traffic_driver

Upstream Avalon-MM master stage of the memory checker. Accepts one test command at a time (read or write burst), drives the Avalon-MM bus with address, burstcount, byteenable and patterned write data, and tracks outstanding read words. Its `read`, `write`, `burstcount` and `byteenable` outputs are the exact signals the measurement stage taps for throughput and latency statistics.

## Interface

Parameters:
- AMM_DATA_W, 128, data bus width; multiple of 32.
- AMM_ADDR_W, 12, address width.
- AMM_BURST_W, 11, burstcount width.
- BYTE_PER_WORD, AMM_DATA_W/8, byteenable width.
- MAX_PENDING_WORDS, 2048, cap on read words requested but not yet returned.

Ports:
- clk_i  in  1  clock; everything is on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  command accepted when `cmd_valid_i && cmd_ready_o`.
- cmd_op_i  in  1  0 = read, 1 = write.
- cmd_addr_i  in  AMM_ADDR_W  burst start address.
- cmd_burstcount_i  in  AMM_BURST_W  beats in the burst.
- cmd_byteenable_i  in  BYTE_PER_WORD  byteenable applied to every beat.
- cmd_seed_i  in  32  write data seed.
- done_o  out  1  one-cycle pulse when a command's bus phase completes.
- busy_o  out  1  state not IDLE, or pending read words non-zero.
- error_o  out  1  sticky error flag; cleared only by `rst_i`.
- address_o  out  AMM_ADDR_W  Avalon-MM address.
- burstcount_o  out  AMM_BURST_W  Avalon-MM burstcount.
- byteenable_o  out  BYTE_PER_WORD  Avalon-MM byteenable.
- writedata_o  out  AMM_DATA_W  Avalon-MM write data.
- write_o  out  1  Avalon-MM write.
- read_o  out  1  Avalon-MM read.
- waitrequest_i  in  1  slave stall.
- readdatavalid_i  in  1  a read word has returned.

## Operation

- **FSM states:** IDLE, WRITE, READ_WAIT, READ.
  - `cmd_ready_o` is 1 only in IDLE.
- **IDLE, command accepted:**
  - Latch address, burstcount, byteenable and seed.
  - Clear the beat counter.
  - Go to WRITE if op = 1; otherwise go to READ_WAIT.
- **Zero-burstcount command:**
  - The command is consumed with no bus activity.
  - `error_o` sets; `done_o` pulses next cycle; the FSM stays in IDLE.
- **WRITE:**
  - `write_o` = 1.
  - `writedata_o` = the 32-bit value (seed + beat) replicated AMM_DATA_W/32 times.
  - A beat is accepted when `write_o && !waitrequest_i`; the beat counter then increments.
  - On acceptance of beat burstcount-1: go to IDLE and pulse `done_o`.
- **READ_WAIT:**
  - If pending + burstcount > MAX_PENDING_WORDS, stay in READ_WAIT with `read_o` = 0.
  - Otherwise go to READ.
- **READ:**
  - `read_o` = 1, held until `!waitrequest_i`.
  - On acceptance: pending += burstcount, go to IDLE, pulse `done_o`.
- **Bus signal stability:** `address_o`, `burstcount_o` and `byteenable_o` hold the latched values for the entire WRITE or READ phase. `writedata_o` holds while `waitrequest_i` = 1.
- **Pending counter:**
  - Width is clog2(MAX_PENDING_WORDS)+1.
  - Decrements by 1 on each `readdatavalid_i`.
  - On read acceptance and `readdatavalid_i` in the same cycle: pending += burstcount - 1.
  - `readdatavalid_i` while pending = 0: `error_o` sets and the counter stays at 0 (no underflow).
- **Ignored inputs:** `readdatavalid_i` is honoured in every state; `cmd_*` is ignored outside IDLE.

## Timing

- **Registered outputs:** all outputs are registered.
- **Bus-phase latency:** command accepted in cycle N gives `write_o`/`read_o` high from N+1 (READ_WAIT adds at least one cycle, so a read's `read_o` rises at N+2 at the earliest).
- **Back-to-back commands:** `cmd_ready_o` rises in the cycle after the final accept. Minimum spacing is one idle cycle between commands.
- **Write throughput:** one beat per cycle when `waitrequest_i` = 0. A B-beat write with no stalls occupies cycles N+1..N+B.
- **`done_o` timing:** asserts in the cycle after the final bus acceptance, coincident with the FSM being in IDLE.
- **Reset values:**
  - FSM = IDLE, pending = 0.
  - `cmd_ready_o` = 1 from the first cycle after `rst_i` deasserts.
  - All other outputs = 0.
- **Reset mid-operation:** `rst_i` mid-burst aborts immediately: `write_o` and `read_o` drop asynchronously and the pending count is discarded.

## Structure

- **Shared package `memory_checker_pkg`:**
  - `op_t` enum (OP_READ = 0, OP_WRITE = 1).
  - `drv_state_t` enum (IDLE, WRITE, READ_WAIT, READ).
- **Sub-module `rd_pending_tracker`:**
  - Inputs: add (burstcount), add_en, dec_en.
  - Outputs: pending count, `would_overflow` for a given burstcount, underflow error pulse.
- The top level holds the FSM, command latch, beat counter and data pattern.

## Test plan

- **Write, no stalls:** write addr=0x010, bc=4, seed=0x100, byteenable=all-ones, `waitrequest_i`=0 → `write_o` high 4 cycles. Words are 0x100..0x103 replicated 4×. `address_o` stays 0x010, `burstcount_o` stays 4. `done_o` pulses on cycle 5.
- **Write, stalled:** bc=2 with `waitrequest_i`=1 for 3 cycles on beat 0 → `writedata_o` holds 0x…100 throughout the stall, then beat 1 carries 0x…101. Total `write_o` high time is 5 cycles.
- **Pending-word limit:** MAX_PENDING_WORDS=8; read bc=6, then read bc=4 with no returns → the second read stays in READ_WAIT with `read_o`=0. After 2 `readdatavalid_i` pulses it issues; pending becomes 8.
- **Simultaneous events:** read bc=3 accepted in the same cycle as one `readdatavalid_i` from a prior bc=1 read → pending goes 1 → 3.
- **Error cases:**
  - `readdatavalid_i` with pending = 0 → `error_o` = 1 and sticky; pending stays 0.
  - Command with bc=0 → `error_o` set, no `read_o`/`write_o`, `done_o` pulses.
- **Reset mid-burst:** `rst_i` asserted on beat 2 of an 8-beat write → `write_o` = 0 immediately. After release: `cmd_ready_o` = 1, `busy_o` = 0, all outputs 0.

Source files
------------

// File: rtl/memory_checker_pkg.sv
// Shared types for the memory checker stages.
package memory_checker_pkg;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        READ_WAIT = 2'd2,
        READ      = 2'd3
    } drv_state_t;

    // 32-bit write pattern for a beat: seed plus beat index.
    function automatic logic [31:0] pattern_word(input logic [31:0] seed, input logic [31:0] beat);
        return seed + beat;
    endfunction

endpackage

// File: rtl/rd_pending_tracker.sv
// Counts read words requested but not yet returned; flags overflow risk and underflow.
module rd_pending_tracker #(
    parameter int MAX_PENDING = 2048,
    parameter int ADD_W       = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ADD_W-1:0] add,
    input  logic             add_en,
    input  logic             dec_en,
    output logic [$clog2(MAX_PENDING):0] count_next,
    output logic             would_overflow,
    output logic             underflow
);
    localparam int CNT_W = $clog2(MAX_PENDING) + 1;
    localparam int SW    = ((CNT_W > ADD_W) ? CNT_W : ADD_W) + 1;

    logic [CNT_W-1:0] count;
    logic [SW-1:0]    sum;

    assign sum            = SW'(count) + SW'(add);
    assign would_overflow = sum > SW'(MAX_PENDING);

    always_comb begin
        count_next = count;
        underflow  = 1'b0;
        if (add_en) begin
            // a word returning in the same cycle is netted against the new burst
            count_next = CNT_W'(sum - SW'(dec_en));
        end else if (dec_en) begin
            if (count == '0) underflow = 1'b1;
            else             count_next = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count <= '0;
        else     count <= count_next;
    end

endmodule

// File: rtl/amm_traffic_driver.sv
// Avalon-MM master driving one read or write burst per command.
// state     | meaning
// IDLE      | waiting for a command (cmd_ready_o high)
// WRITE     | issuing write beats, one per accepted cycle
// READ_WAIT | holding a read until pending words leave room
// READ      | read request on the bus until accepted
module amm_traffic_driver
    import memory_checker_pkg::*;
#(
    parameter int AMM_DATA_W        = 128,
    parameter int AMM_ADDR_W        = 12,
    parameter int AMM_BURST_W       = 11,
    parameter int BYTE_PER_WORD     = AMM_DATA_W / 8,
    parameter int MAX_PENDING_WORDS = 2048
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic                     cmd_op_i,
    input  logic [AMM_ADDR_W-1:0]    cmd_addr_i,
    input  logic [AMM_BURST_W-1:0]   cmd_burstcount_i,
    input  logic [BYTE_PER_WORD-1:0] cmd_byteenable_i,
    input  logic [31:0]              cmd_seed_i,
    output logic                     done_o,
    output logic                     busy_o,
    output logic                     error_o,
    output logic [AMM_ADDR_W-1:0]    address_o,
    output logic [AMM_BURST_W-1:0]   burstcount_o,
    output logic [BYTE_PER_WORD-1:0] byteenable_o,
    output logic [AMM_DATA_W-1:0]    writedata_o,
    output logic                     write_o,
    output logic                     read_o,
    input  logic                     waitrequest_i,
    input  logic                     readdatavalid_i
);
    localparam int REPS = AMM_DATA_W / 32;

    drv_state_t                    state;
    logic [AMM_BURST_W-1:0]        beat;
    logic [AMM_BURST_W-1:0]        beat_inc;
    logic [31:0]                   seed;
    logic [$clog2(MAX_PENDING_WORDS):0] pend_next;
    logic                          would_overflow;
    logic                          underflow;
    logic                          read_accept;

    assign beat_inc    = beat + AMM_BURST_W'(1);
    assign read_accept = read_o && !waitrequest_i;

    rd_pending_tracker #(
        .MAX_PENDING (MAX_PENDING_WORDS),
        .ADD_W       (AMM_BURST_W)
    ) u_pending (
        .clk            (clk_i),
        .rst            (rst_i),
        .add            (burstcount_o),
        .add_en         (read_accept),
        .dec_en         (readdatavalid_i),
        .count_next     (pend_next),
        .would_overflow (would_overflow),
        .underflow      (underflow)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            beat         <= '0;
            seed         <= '0;
            cmd_ready_o  <= 1'b1;
            done_o       <= 1'b0;
            busy_o       <= 1'b0;
            error_o      <= 1'b0;
            address_o    <= '0;
            burstcount_o <= '0;
            byteenable_o <= '0;
            writedata_o  <= '0;
            write_o      <= 1'b0;
            read_o       <= 1'b0;
        end else begin
            done_o  <= 1'b0;
            busy_o  <= 1'b1;
            error_o <= error_o | underflow;
            unique case (state)
                IDLE: begin
                    busy_o <= pend_next != '0;
                    if (cmd_valid_i) begin
                        if (cmd_burstcount_i == '0) begin
                            error_o <= 1'b1;
                            done_o  <= 1'b1;
                        end else begin
                            address_o    <= cmd_addr_i;
                            burstcount_o <= cmd_burstcount_i;
                            byteenable_o <= cmd_byteenable_i;
                            seed         <= cmd_seed_i;
                            beat         <= '0;
                            cmd_ready_o  <= 1'b0;
                            busy_o       <= 1'b1;
                            if (op_t'(cmd_op_i) == OP_WRITE) begin
                                state       <= WRITE;
                                write_o     <= 1'b1;
                                writedata_o <= {REPS{cmd_seed_i}};
                            end else begin
                                state <= READ_WAIT;
                            end
                        end
                    end
                end
                WRITE: begin
                    if (!waitrequest_i) begin
                        beat <= beat_inc;
                        if (beat_inc == burstcount_o) begin
                            state       <= IDLE;
                            write_o     <= 1'b0;
                            done_o      <= 1'b1;
                            cmd_ready_o <= 1'b1;
                            busy_o      <= pend_next != '0;
                        end else begin
                            writedata_o <= {REPS{pattern_word(seed, 32'(beat_inc))}};
                        end
                    end
                end
                READ_WAIT: begin
                    if (!would_overflow) begin
                        state  <= READ;
                        read_o <= 1'b1;
                    end
                end
                READ: begin
                    if (!waitrequest_i) begin
                        state       <= IDLE;
                        read_o      <= 1'b0;
                        done_o      <= 1'b1;
                        cmd_ready_o <= 1'b1;
                        busy_o      <= pend_next != '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
